// File: rtl/mem_arbiter.sv
//==============================================================================
// Module   : mem_arbiter
// Brief    : N-channel to single-bus arbiter with an in-order tag FIFO for
//            response routing. Optional macro MEM_ARB_RR_EN selects round-robin
//            arbitration; otherwise fixed priority, lowest index wins.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int CH    = 2,
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CH-1:0]             ch_req,
  input  logic [CH-1:0]             ch_cmd,
  input  logic [2*CH-1:0]           ch_width,
  input  logic [CH*XLEN-1:0]        ch_addr,
  input  logic [CH*XLEN-1:0]        ch_wdata,
  output logic [CH-1:0]             ch_gnt,
  output logic [CH-1:0]             ch_resp,
  output logic [XLEN-1:0]           ch_rdata,
  output logic [CH-1:0]             ch_err,
  output logic                      bus_req,
  output logic                      bus_cmd,
  output logic [1:0]                bus_width,
  output logic [XLEN-1:0]           bus_addr,
  output logic [XLEN-1:0]           bus_wdata,
  input  logic                      bus_gnt,
  input  logic                      bus_resp,
  input  logic                      bus_err,
  input  logic [XLEN-1:0]           bus_rdata,
  output logic [$clog2(DEPTH):0]    outst_cnt,
  output logic                      stray_resp
);

  localparam int TW = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [TW-1:0] w_sel;
  logic [TW-1:0] w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  logic [TW-1:0] r_tag [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          r_stray;

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign bus_req = (|ch_req) & ~w_full;
  // Grants are suppressed while reset is asserted so nothing leaks upstream.
  assign w_push  = bus_req & bus_gnt & rst;
  assign w_pop   = bus_resp & ~w_empty;
  assign w_head  = r_tag[r_rptr];

`ifdef MEM_ARB_RR_EN
  logic [TW-1:0] r_rr_ptr;

  always_comb begin
    int  v_idx;
    logic v_found;
    w_sel   = '0;
    v_idx   = 0;
    v_found = 1'b0;
    for (int i = 0; i < CH; i++) begin
      v_idx = int'(r_rr_ptr) + i;
      if (v_idx >= CH) v_idx = v_idx - CH;
      if (!v_found && ch_req[v_idx]) begin
        w_sel   = TW'(v_idx);
        v_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr <= '0;
    end else if (w_push) begin
      r_rr_ptr <= (w_sel == TW'(CH - 1)) ? '0 : w_sel + 1'b1;
    end
  end
`else
  always_comb begin
    w_sel = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (ch_req[i]) w_sel = TW'(i);
    end
  end
`endif

  assign bus_cmd   = bus_req & ch_cmd[w_sel];
  assign bus_width = bus_req ? ch_width[w_sel*2 +: 2]       : 2'b00;
  assign bus_addr  = bus_req ? ch_addr[w_sel*XLEN +: XLEN]  : '0;
  assign bus_wdata = bus_req ? ch_wdata[w_sel*XLEN +: XLEN] : '0;

  always_comb begin
    ch_gnt  = '0;
    ch_resp = '0;
    ch_err  = '0;
    if (w_push) ch_gnt[w_sel] = 1'b1;
    if (w_pop) begin
      ch_resp[w_head] = 1'b1;
      ch_err[w_head]  = bus_err;
    end
  end

  assign ch_rdata   = bus_rdata;
  assign outst_cnt  = r_cnt;
  assign stray_resp = r_stray;

  // Tag storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_tag[r_wptr] <= w_sel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_stray <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      r_stray <= bus_resp & w_empty;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//==============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter (CH=2, DEPTH=4).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int CH    = 2;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   ch_req;
  logic [CH-1:0]   ch_cmd;
  logic [2*CH-1:0] ch_width;
  logic [CH*XLEN-1:0] ch_addr;
  logic [CH*XLEN-1:0] ch_wdata;
  logic [CH-1:0]   ch_gnt;
  logic [CH-1:0]   ch_resp;
  logic [XLEN-1:0] ch_rdata;
  logic [CH-1:0]   ch_err;
  logic            bus_req;
  logic            bus_cmd;
  logic [1:0]      bus_width;
  logic [XLEN-1:0] bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic            bus_gnt;
  logic            bus_resp;
  logic            bus_err;
  logic [XLEN-1:0] bus_rdata;
  logic [2:0]      outst_cnt;
  logic            stray_resp;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.CH(CH), .XLEN(XLEN), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .ch_req(ch_req), .ch_cmd(ch_cmd), .ch_width(ch_width),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_gnt(ch_gnt), .ch_resp(ch_resp), .ch_rdata(ch_rdata), .ch_err(ch_err),
    .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_width(bus_width),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_resp(bus_resp), .bus_err(bus_err),
    .bus_rdata(bus_rdata),
    .outst_cnt(outst_cnt), .stray_resp(stray_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_g;
  logic [1:0] prev_g;

  initial begin
    rst       = 1'b0;
    ch_req    = 2'b11;
    ch_cmd    = 2'b10;
    ch_width  = 4'b1001;
    ch_addr   = {32'h0000_0200, 32'h0000_0100};
    ch_wdata  = {32'h0000_BBBB, 32'h0000_AAAA};
    bus_gnt   = 1'b1;
    bus_resp  = 1'b0;
    bus_err   = 1'b0;
    bus_rdata = 32'h0;

    // Reset state with requests and bus_gnt active
    tick(); tick();
    check("rst_cnt",   32'(outst_cnt),  0);
    check("rst_stray", 32'(stray_resp), 0);
    check("rst_gnt",   32'(ch_gnt),     0);
    check("rst_busreq", 32'(bus_req),   1);
    check("rst_addr",  bus_addr, 32'h100);
    ch_req = 2'b00;
    #1;
    check("idle_busreq", 32'(bus_req),   0);
    check("idle_addr",   bus_addr,       0);
    check("idle_width",  32'(bus_width), 0);
    rst = 1'b1;
    tick();

    // Continuous requests, response one cycle after grant
    ch_req = 2'b11;
    prev_g = 2'b00;
    for (int i = 0; i < 4; i++) begin
      bus_resp = (i > 0);
      exp_g = (RR && (i % 2 == 1)) ? 2'b10 : 2'b01;
      #1;
      check("arb_gnt",  32'(ch_gnt), 32'(exp_g));
      check("arb_addr", bus_addr, (exp_g == 2'b01) ? 32'h100 : 32'h200);
      check("arb_cmd",  32'(bus_cmd), (exp_g == 2'b01) ? 0 : 1);
      check("arb_wid",  32'(bus_width), (exp_g == 2'b01) ? 1 : 2);
      if (i > 0) check("arb_resp", 32'(ch_resp), 32'(prev_g));
      prev_g = exp_g;
      tick();
      check("arb_cnt", 32'(outst_cnt), 1);
    end
    ch_req   = 2'b00;
    bus_resp = 1'b1;
    #1;
    check("arb_drain_resp", 32'(ch_resp), 32'(prev_g));
    tick();
    bus_resp = 1'b0;
    check("arb_drain_cnt", 32'(outst_cnt), 0);

    // Fill to DEPTH, then one pop and regrant a cycle later
    ch_req = 2'b01;
    for (int i = 0; i < 4; i++) tick();
    check("full_cnt",    32'(outst_cnt), 4);
    check("full_busreq", 32'(bus_req),   0);
    check("full_gnt",    32'(ch_gnt),    0);
    bus_resp = 1'b1;
    #1;
    check("full_pop_gnt",  32'(ch_gnt),  0);
    check("full_pop_resp", 32'(ch_resp), 1);
    tick();
    bus_resp = 1'b0;
    check("full_cnt3", 32'(outst_cnt), 3);
    #1;
    check("full_regrant", 32'(ch_gnt), 1);
    tick();
    check("full_cnt4", 32'(outst_cnt), 4);
    ch_req   = 2'b00;
    bus_resp = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus_resp = 1'b0;
    check("full_drain", 32'(outst_cnt), 0);

    // In-order routing: ch1, ch0, ch1
    ch_req = 2'b10; tick();
    ch_req = 2'b01; tick();
    ch_req = 2'b10; tick();
    ch_req = 2'b00;
    check("order_cnt", 32'(outst_cnt), 3);
    bus_resp  = 1'b1;
    bus_rdata = 32'hA;
    #1;
    check("order_r1",  32'(ch_resp), 2);
    check("order_d1",  ch_rdata, 32'hA);
    tick();
    bus_rdata = 32'hB;
    #1;
    check("order_r2",  32'(ch_resp), 1);
    check("order_d2",  ch_rdata, 32'hB);
    tick();
    bus_rdata = 32'hC;
    #1;
    check("order_r3",  32'(ch_resp), 2);
    check("order_d3",  ch_rdata, 32'hC);
    tick();
    bus_resp = 1'b0;
    check("order_cnt0", 32'(outst_cnt), 0);

    // Error response for ch0
    ch_req = 2'b01; tick();
    ch_req   = 2'b00;
    bus_resp = 1'b1;
    bus_err  = 1'b1;
    #1;
    check("err_resp", 32'(ch_resp), 1);
    check("err_flag", 32'(ch_err),  1);
    tick();
    bus_resp = 1'b0;
    #1;
    check("err_idle", 32'(ch_err), 0);
    bus_err = 1'b0;

    // Stray response with nothing in flight
    bus_resp = 1'b1;
    #1;
    check("stray_resp0", 32'(ch_resp),    0);
    check("stray_pre",   32'(stray_resp), 0);
    tick();
    bus_resp = 1'b0;
    check("stray_pulse", 32'(stray_resp), 1);
    check("stray_cnt",   32'(outst_cnt),  0);
    tick();
    check("stray_clear", 32'(stray_resp), 0);

    // Reset with three in flight, then a late response
    ch_req = 2'b01;
    for (int i = 0; i < 3; i++) tick();
    ch_req = 2'b00;
    check("mid_cnt3", 32'(outst_cnt), 3);
    rst = 1'b0;
    #1;
    check("mid_rst_cnt", 32'(outst_cnt), 0);
    tick();
    rst      = 1'b1;
    bus_resp = 1'b1;
    #1;
    check("mid_resp", 32'(ch_resp), 0);
    tick();
    bus_resp = 1'b0;
    check("mid_stray", 32'(stray_resp), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter CH, default 2: number of requesting channels, 2..8.
REQ-002 Parameter XLEN, default 32: address and data width.
REQ-003 Parameter DEPTH, default 4: maximum outstanding bus transactions, power of two, 2..16.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 ch_req  input  CH  per-channel request valid.
REQ-007 ch_cmd  input  CH  per-channel command, 1 = write, 0 = read.
REQ-008 ch_width  input  2*CH  per-channel access width code.
REQ-009 ch_addr  input  CH*XLEN  per-channel address.
REQ-010 ch_wdata  input  CH*XLEN  per-channel write data.
REQ-011 ch_gnt  output  CH  one-hot; request accepted this cycle.
REQ-012 ch_resp  output  CH  one-hot; response for the channel this cycle.
REQ-013 ch_rdata  output  XLEN  read data, broadcast to all channels.
REQ-014 ch_err  output  CH  error flag, qualified by ch_resp.
REQ-015 bus_req, bus_cmd, bus_width[2], bus_addr[XLEN], bus_wdata[XLEN]  output  downstream request.
REQ-016 bus_gnt  input  1  downstream accepts bus_req this cycle.
REQ-017 bus_resp, bus_err, bus_rdata[XLEN]  input  downstream response; responses return in request order.
REQ-018 outst_cnt  output  log2(DEPTH)+1  number of in-flight transactions.
REQ-019 stray_resp  output  1  registered one-cycle pulse; bus_resp arrived with no transaction in flight.

Function
REQ-020 Arbitration is combinational; bus_req is high when any ch_req is high and outst_cnt < DEPTH.
REQ-021 bus_cmd, bus_width, bus_addr and bus_wdata are driven from the selected channel. They are zero when bus_req is low.
REQ-022 ch_gnt[k] = selected(k) & bus_gnt & bus_req. At most one grant per cycle.
REQ-023 On each grant, the granted channel index is pushed into a DEPTH-entry in-order tag FIFO.
REQ-024 On bus_resp with the FIFO non-empty:
- ch_resp[head] = 1 and ch_err[head] = bus_err in the same cycle (zero added latency).
- ch_rdata = bus_rdata.
- The head entry is popped.
REQ-025 Push and pop in the same cycle leave outst_cnt unchanged. Pointers wrap modulo DEPTH.
REQ-026 FIFO full (outst_cnt == DEPTH): bus_req is forced low and no grant is issued, even if a pop occurs that cycle.
REQ-027 bus_resp with the FIFO empty: all ch_resp stay low, nothing is popped, and stray_resp pulses in the next cycle.
REQ-028 A requester holds ch_req and its payload stable until ch_gnt. The arbiter may change its selection while bus_gnt is low.
REQ-029 ch_rdata equals bus_rdata at all times; ch_err is zero when no response is active.

Reset
REQ-030 While rst is low:
- FIFO pointers, outst_cnt and stray_resp = 0.
- The round-robin pointer selects channel 0 as highest priority.
REQ-031 Reset mid-transaction discards all in-flight tags. Responses arriving after reset release are treated as stray.
REQ-032 Combinational outputs follow REQ-020..REQ-029 from the reset state; ch_gnt and ch_resp are all zero during reset.

Configuration
REQ-033 Macro MEM_ARB_RR_EN.
- Defined: round-robin. Priority starts at the channel after the last granted channel; the pointer updates only on a grant.
- Undefined: fixed priority, lowest index wins. The pointer register is not implemented.

Verification
REQ-034 CH=2, DEPTH=4, both channels request continuously, bus_gnt=1, response one cycle after grant.
- RR_EN defined: grants alternate 0,1,0,1.
- RR_EN undefined: channel 0 granted every cycle.
REQ-035 Issue 4 grants with bus_resp held low: outst_cnt=4 and bus_req=0. One bus_resp then pops, and the next grant occurs one cycle later.
REQ-036 Grants to ch1, ch0, ch1, then three responses with rdata 0xA, 0xB, 0xC: ch_resp sequence is ch1/0xA, ch0/0xB, ch1/0xC.
REQ-037 bus_resp=1 with outst_cnt=0: no ch_resp, and stray_resp=1 for exactly one cycle afterward.
REQ-038 Assert rst low with 3 transactions in flight: outst_cnt=0 immediately. The following bus_resp raises stray_resp.
REQ-039 bus_resp with bus_err=1 for a ch0 transaction: ch_resp[0]=1, ch_err[0]=1, ch_err[1]=0.
